// File: rtl/rab_cfg_pkg.sv
// Shared types and constants for the RAB configuration AXI-Lite initiator.
// Holds the AXI response codes, the master FSM states and the latched command layout.
package rab_cfg_pkg;

    localparam int unsigned CFG_ADDR_WIDTH = 32;
    localparam int unsigned CFG_DATA_WIDTH = 64;
    localparam int unsigned CFG_STRB_WIDTH = CFG_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } cfg_state_e;

    typedef struct packed {
        logic                      we;
        logic [CFG_ADDR_WIDTH-1:0] addr;
        logic [CFG_DATA_WIDTH-1:0] wdata;
        logic [CFG_STRB_WIDTH-1:0] wstrb;
    } cfg_cmd_t;

    // EXOKAY counts as success; only SLVERR and DECERR are errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/rab_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module rab_sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/rab_cfg_lite_master.sv
// AXI4-Lite initiator turning single write/read commands into full AXI-Lite transactions,
// returning status/data over a valid/ready response port and keeping saturating statistics.
module rab_cfg_lite_master
    import rab_cfg_pkg::*;
#(
    parameter int unsigned AXI_LITE_ADDR_WIDTH = CFG_ADDR_WIDTH,
    parameter int unsigned AXI_LITE_DATA_WIDTH = CFG_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH           = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,

    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic                             cmd_we_i,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [AXI_LITE_DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [AXI_LITE_DATA_WIDTH/8-1:0] cmd_wstrb_i,

    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [AXI_LITE_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]                       rsp_resp_o,
    output logic                             rsp_err_o,

    output logic [AXI_LITE_ADDR_WIDTH-1:0]   cfg_awaddr_o,
    output logic [2:0]                       cfg_awprot_o,
    output logic                             cfg_awvalid_o,
    input  logic                             cfg_awready_i,

    output logic [AXI_LITE_DATA_WIDTH-1:0]   cfg_wdata_o,
    output logic [AXI_LITE_DATA_WIDTH/8-1:0] cfg_wstrb_o,
    output logic                             cfg_wvalid_o,
    input  logic                             cfg_wready_i,

    input  logic [1:0]                       cfg_bresp_i,
    input  logic                             cfg_bvalid_i,
    output logic                             cfg_bready_o,

    output logic [AXI_LITE_ADDR_WIDTH-1:0]   cfg_araddr_o,
    output logic [2:0]                       cfg_arprot_o,
    output logic                             cfg_arvalid_o,
    input  logic                             cfg_arready_i,

    input  logic [AXI_LITE_DATA_WIDTH-1:0]   cfg_rdata_i,
    input  logic [1:0]                       cfg_rresp_i,
    input  logic                             cfg_rvalid_i,
    output logic                             cfg_rready_o,

    output logic [CNT_WIDTH-1:0]             n_wr_o,
    output logic [CNT_WIDTH-1:0]             n_rd_o,
    output logic [CNT_WIDTH-1:0]             n_err_o,
    output logic                             busy_o
);

    cfg_state_e                     state_q;
    cfg_cmd_t                       cmd_q;
    logic                           awvalid_q;
    logic                           wvalid_q;
    logic                           bready_q;
    logic                           arvalid_q;
    logic                           rready_q;
    logic                           rsp_valid_q;
    logic                           aw_done_q;
    logic                           w_done_q;
    logic [AXI_LITE_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                     resp_q;

    logic aw_hs;
    logic w_hs;
    logic rsp_hs;

    assign aw_hs  = awvalid_q & cfg_awready_i;
    assign w_hs   = wvalid_q & cfg_wready_i;
    assign rsp_hs = rsp_valid_q & rsp_ready_i;

    // The AW and W channels retire independently; the write phase ends on the edge
    // where the later of the two handshakes lands, so bready rises the very next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_q.we    <= cmd_we_i;
                        cmd_q.addr  <= cmd_addr_i;
                        cmd_q.wdata <= cmd_wdata_i;
                        cmd_q.wstrb <= cmd_wstrb_i;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        if (cmd_we_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (cfg_bvalid_i) begin
                        bready_q    <= 1'b0;
                        resp_q      <= cfg_bresp_i;
                        rdata_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (cfg_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (cfg_rvalid_i) begin
                        rready_q    <= 1'b0;
                        rdata_q     <= cfg_rdata_i;
                        resp_q      <= cfg_rresp_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);

    assign cfg_awaddr_o  = cmd_q.addr;
    assign cfg_awprot_o  = 3'b000;
    assign cfg_awvalid_o = awvalid_q;
    assign cfg_wdata_o   = cmd_q.wdata;
    assign cfg_wstrb_o   = cmd_q.wstrb;
    assign cfg_wvalid_o  = wvalid_q;
    assign cfg_bready_o  = bready_q;
    assign cfg_araddr_o  = cmd_q.addr;
    assign cfg_arprot_o  = 3'b000;
    assign cfg_arvalid_o = arvalid_q;
    assign cfg_rready_o  = rready_q;

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_resp_o    = resp_q;
    assign rsp_err_o     = resp_is_err(resp_q);

    // Statistics only advance when the requester has consumed the response.
    rab_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_wr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (rsp_hs & cmd_q.we),
        .cnt_o  (n_wr_o)
    );

    rab_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_rd (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (rsp_hs & ~cmd_q.we),
        .cnt_o  (n_rd_o)
    );

    rab_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_err (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (rsp_hs & resp_is_err(resp_q)),
        .cnt_o  (n_err_o)
    );

endmodule

// File: tb/tb_rab_cfg_lite_master.sv
// Self-checking bench for rab_cfg_lite_master: a task-driven AXI-Lite slave plus a
// transaction-level reference model (latency rule, response values, saturating counts).
module tb_rab_cfg_lite_master;
    import rab_cfg_pkg::*;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [CW-1:0] n_wr, n_rd, n_err;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_wr   = 0;
    int m_rd   = 0;
    int m_err  = 0;
    bit aw_hs_seen, w_hs_seen;

    always #5 clk = ~clk;

    rab_cfg_lite_master #(
        .AXI_LITE_ADDR_WIDTH (32),
        .AXI_LITE_DATA_WIDTH (64),
        .CNT_WIDTH           (CW)
    ) dut (
        .clk_i (clk), .rst_ni (rst_n),
        .cmd_valid_i (cmd_valid), .cmd_ready_o (cmd_ready), .cmd_we_i (cmd_we),
        .cmd_addr_i (cmd_addr), .cmd_wdata_i (cmd_wdata), .cmd_wstrb_i (cmd_wstrb),
        .rsp_valid_o (rsp_valid), .rsp_ready_i (rsp_ready), .rsp_rdata_o (rsp_rdata),
        .rsp_resp_o (rsp_resp), .rsp_err_o (rsp_err),
        .cfg_awaddr_o (awaddr), .cfg_awprot_o (awprot), .cfg_awvalid_o (awvalid), .cfg_awready_i (awready),
        .cfg_wdata_o (wdata), .cfg_wstrb_o (wstrb), .cfg_wvalid_o (wvalid), .cfg_wready_i (wready),
        .cfg_bresp_i (bresp), .cfg_bvalid_i (bvalid), .cfg_bready_o (bready),
        .cfg_araddr_o (araddr), .cfg_arprot_o (arprot), .cfg_arvalid_o (arvalid), .cfg_arready_i (arready),
        .cfg_rdata_i (rdata), .cfg_rresp_i (rresp), .cfg_rvalid_i (rvalid), .cfg_rready_o (rready),
        .n_wr_o (n_wr), .n_rd_o (n_rd), .n_err_o (n_err), .busy_o (busy)
    );

    function automatic int sat(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic slave_aw(input logic [31:0] addr, input int dly);
        int n = 0;
        bit early = 0;
        while (!awvalid && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (awvalid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL aw_timeout: awvalid=%b required 1", awvalid); return;
        end
        repeat (dly) begin @(negedge clk); if (awvalid !== 1'b1) early = 1; end
        n_cmp++;
        if (early) begin n_fail++; $display("[TB] FAIL aw_hold: awvalid dropped early, required held"); end
        n_cmp++;
        if (awaddr !== addr || awprot !== 3'b000) begin
            n_fail++; $display("[TB] FAIL aw_addr: got %h/%b required %h/000", awaddr, awprot, addr);
        end
        awready = 1'b1;
        @(posedge clk); aw_hs_seen = 1;
        @(negedge clk); awready = 1'b0;
        n_cmp++;
        if (awvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL aw_drop: awvalid=%b required 0", awvalid); end
    endtask

    task automatic slave_w(input logic [63:0] data, input logic [7:0] strb, input int dly);
        int n = 0;
        bit early = 0;
        while (!wvalid && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (wvalid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL w_timeout: wvalid=%b required 1", wvalid); return;
        end
        repeat (dly) begin @(negedge clk); if (wvalid !== 1'b1) early = 1; end
        n_cmp++;
        if (early) begin n_fail++; $display("[TB] FAIL w_hold: wvalid dropped early, required held"); end
        n_cmp++;
        if (wdata !== data || wstrb !== strb) begin
            n_fail++; $display("[TB] FAIL w_data: got %h/%h required %h/%h", wdata, wstrb, data, strb);
        end
        wready = 1'b1;
        @(posedge clk); w_hs_seen = 1;
        @(negedge clk); wready = 1'b0;
        n_cmp++;
        if (wvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL w_drop: wvalid=%b required 0", wvalid); end
    endtask

    task automatic slave_b(input logic [1:0] resp, input int dly);
        int n = 0;
        while (!bready && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (bready !== 1'b1 || !(aw_hs_seen && w_hs_seen)) begin
            n_fail++;
            $display("[TB] FAIL b_order: bready=%b aw_done=%b w_done=%b required all 1", bready, aw_hs_seen, w_hs_seen);
            return;
        end
        repeat (dly) @(negedge clk);
        bvalid = 1'b1; bresp = resp;
        @(posedge clk);
        @(negedge clk); bvalid = 1'b0; bresp = 2'($urandom);
    endtask

    task automatic slave_ar(input logic [31:0] addr, input int dly);
        int n = 0;
        bit early = 0;
        while (!arvalid && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (arvalid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL ar_timeout: arvalid=%b required 1", arvalid); return;
        end
        repeat (dly) begin @(negedge clk); if (arvalid !== 1'b1) early = 1; end
        n_cmp++;
        if (early || araddr !== addr || arprot !== 3'b000) begin
            n_fail++; $display("[TB] FAIL ar_addr: got %h/%b held=%b required %h/000 held", araddr, arprot, !early, addr);
        end
        arready = 1'b1;
        @(posedge clk);
        @(negedge clk); arready = 1'b0;
    endtask

    task automatic slave_r(input logic [63:0] data, input logic [1:0] resp, input int dly);
        int n = 0;
        while (!rready && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (rready !== 1'b1 || arvalid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL r_order: rready=%b arvalid=%b required 1/0", rready, arvalid); return;
        end
        repeat (dly) @(negedge clk);
        rvalid = 1'b1; rdata = data; rresp = resp;
        @(posedge clk);
        @(negedge clk); rvalid = 1'b0; rdata = {$urandom, $urandom}; rresp = 2'($urandom);
    endtask

    task automatic wait_rsp(output int lat, output bit saw_ready);
        lat = 1;
        saw_ready = cmd_ready;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk); lat++;
            if (cmd_ready) saw_ready = 1;
        end
    endtask

    // One complete command: data is the write data for writes and the slave's read data for reads.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input int d1, input int d2, input int d3,
                          input logic [1:0] resp, input int hold, input string name);
        int lat, exp_lat;
        bit saw_ready, stable;
        logic [63:0] cap_rdata, exp_rdata;
        logic [1:0]  cap_resp;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL %s cmd_ready_idle: got %b required 1", name, cmd_ready); end
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = $urandom;
        cmd_wdata = {$urandom, $urandom}; cmd_wstrb = 8'($urandom);
        aw_hs_seen = 0; w_hs_seen = 0;
        if (we) begin
            fork
                slave_aw(addr, d1);
                slave_w(data, strb, d2);
                slave_b(resp, d3);
                wait_rsp(lat, saw_ready);
            join
            exp_lat = 3 + ((d1 > d2) ? d1 : d2) + d3;
        end else begin
            fork
                slave_ar(addr, d1);
                slave_r(data, resp, d3);
                wait_rsp(lat, saw_ready);
            join
            exp_lat = 3 + d1 + d3;
        end
        n_cmp++;
        if (lat !== exp_lat) begin n_fail++; $display("[TB] FAIL %s latency: got %0d required %0d", name, lat, exp_lat); end
        if (rsp_valid !== 1'b1) return;
        n_cmp++;
        if (saw_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL %s cmd_ready_busy: seen %b required 0", name, saw_ready); end
        exp_rdata = we ? 64'd0 : data;
        n_cmp++;
        if (rsp_rdata !== exp_rdata || rsp_resp !== resp || rsp_err !== resp[1]) begin
            n_fail++;
            $display("[TB] FAIL %s rsp: got %h/%b/%b required %h/%b/%b", name, rsp_rdata, rsp_resp, rsp_err, exp_rdata, resp, resp[1]);
        end
        cap_rdata = rsp_rdata; cap_resp = rsp_resp; stable = 1;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== cap_rdata || rsp_resp !== cap_resp || cmd_ready !== 1'b0) stable = 0;
        end
        if (hold > 0) begin
            n_cmp++;
            if (!stable) begin n_fail++; $display("[TB] FAIL %s rsp_hold: stable=%b required 1", name, stable); end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        if (we) m_wr++; else m_rd++;
        if (resp[1]) m_err++;
        @(negedge clk); rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL %s rsp_done: valid/ready/busy=%b%b%b required 010", name, rsp_valid, cmd_ready, busy);
        end
        n_cmp++;
        if (n_wr !== CW'(sat(m_wr)) || n_rd !== CW'(sat(m_rd)) || n_err !== CW'(sat(m_err))) begin
            n_fail++;
            $display("[TB] FAIL %s counters: got %0d/%0d/%0d required %0d/%0d/%0d", name, n_wr, n_rd, n_err, sat(m_wr), sat(m_rd), sat(m_err));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        #12;
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy} !== 7'd0) begin
            n_fail++; $display("[TB] FAIL reset_ctrl: got %b required 0000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy});
        end
        n_cmp++;
        if (n_wr !== 0 || n_rd !== 0 || n_err !== 0 || rsp_rdata !== 0 || rsp_resp !== 0 || awaddr !== 0 || wdata !== 0) begin
            n_fail++; $display("[TB] FAIL reset_data: cnt %0d/%0d/%0d rdata %h resp %b required zeros", n_wr, n_rd, n_err, rsp_rdata, rsp_resp);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b required 1", cmd_ready); end
    endtask

    task automatic test_write_basic();
        do_txn(1'b1, 32'h20, 64'h0000_0001_0000_0001, 8'hFF, 0, 0, 0, RESP_OKAY, 0, "wr_basic");
    endtask

    task automatic test_write_wdelay();
        do_txn(1'b1, 32'h28, {$urandom, $urandom}, 8'h0F, 0, 3, 0, RESP_OKAY, 0, "wr_wdelay");
    endtask

    task automatic test_read_basic();
        do_txn(1'b0, 32'h38, 64'hDEADBEEF_CAFEF00D, 8'h00, 0, 0, 0, RESP_OKAY, 0, "rd_basic");
    endtask

    task automatic test_write_slverr();
        do_txn(1'b1, 32'h40, {$urandom, $urandom}, 8'hF0, 0, 0, 0, RESP_SLVERR, 0, "wr_slverr");
    endtask

    task automatic test_back_to_back();
        do_txn(1'b0, 32'h48, {$urandom, $urandom}, 8'h00, 1, 0, 1, RESP_EXOKAY, 5, "bp_hold");
        do_txn(1'b1, 32'h50, {$urandom, $urandom}, 8'hAA, 0, 0, 0, RESP_OKAY, 0, "bp_next");
    endtask

    task automatic test_random(input int count, input bit only_writes, input string name);
        for (int i = 0; i < count; i++) begin
            do_txn(only_writes ? 1'b1 : 1'($urandom), $urandom & 32'h0000_FFFC, {$urandom, $urandom},
                   8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   2'($urandom), $urandom_range(0, 2), name);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h60;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        arready = 1'b1;
        @(posedge clk);
        @(negedge clk); arready = 1'b0;
        n_cmp++;
        if (rready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_reach: rready=%b required 1", rready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, rready, rsp_valid, busy} !== 4'd0) begin
            n_fail++; $display("[TB] FAIL rst_mid_ctrl: got %b required 0000", {arvalid, rready, rsp_valid, busy});
        end
        n_cmp++;
        if (n_wr !== 0 || n_rd !== 0 || n_err !== 0) begin
            n_fail++; $display("[TB] FAIL rst_mid_cnt: got %0d/%0d/%0d required 0/0/0", n_wr, n_rd, n_err);
        end
        m_wr = 0; m_rd = 0; m_err = 0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        test_random(20, 1'b1, "sat");
        n_cmp++;
        if (n_wr !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_final: n_wr=%0d required 15", n_wr); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_write_wdelay();
        test_read_basic();
        test_write_slverr();
        test_back_to_back();
        test_random(20, 1'b0, "rand");
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
